// File: rtl/mmio_timer.sv
// mmio_timer: memory-mapped down-counting timer with autoreload, sticky flag and level interrupt.
// Registers: CTRL at BASE_ADDRESS, LOAD at +1, COUNT at +2, STATUS at +3.
module mmio_timer #(
    parameter logic [31:0] BASE_ADDRESS = 32'd248,
    parameter int          CNT_W        = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] mem_address,
    inout  wire  [63:0] mem_data,
    input  logic        mem_cs,
    input  logic        mem_write_en,
    input  logic        mem_read,
    output logic        timer_irq
);
    typedef enum logic [1:0] {IDLE, RUNNING, DONE} state_t;

    state_t           state_q, state_d;
    logic [3:0]       ctrl_q, ctrl_d;
    logic [CNT_W-1:0] load_q, load_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             flag_q, flag_d;
    logic [31:0]      offset;
    logic [1:0]       off;
    logic             hit, wr, rd, wr_ctrl, wr_load, wr_stat;
    logic [63:0]      rdata;
    logic             unused_bus;

    // Subtracting first keeps the range test correct even when BASE sits near the top of the map.
    assign offset     = mem_address - BASE_ADDRESS;
    assign off        = offset[1:0];
    assign hit        = mem_cs && offset < 32'd4;
    assign wr         = hit && mem_write_en;
    assign rd         = hit && mem_read && !mem_write_en;
    assign wr_ctrl    = wr && off == 2'd0;
    assign wr_load    = wr && off == 2'd1;
    assign wr_stat    = wr && off == 2'd3;
    assign unused_bus = ^mem_data;

    always_comb begin
        rdata = off == 2'd0 ? {60'b0, ctrl_q} :
                off == 2'd1 ? 64'(load_q) :
                off == 2'd2 ? 64'(count_q) :
                {62'b0, state_q == RUNNING, flag_q};
    end

    assign mem_data  = rd ? rdata : 64'bz;
    assign timer_irq = flag_q & ctrl_q[3];

    always_comb begin
        ctrl_d  = ctrl_q;
        load_d  = load_q;
        count_d = count_q;
        state_d = state_q;
        flag_d  = flag_q;
        if (wr_ctrl) ctrl_d = {mem_data[3:2], 1'b0, mem_data[0]};
        if (wr_load) load_d = mem_data[CNT_W-1:0];
        if (wr_stat && mem_data[0]) flag_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (wr_ctrl && mem_data[0]) begin
                    state_d = RUNNING;
                    count_d = load_q;
                end else if (wr_load) begin
                    count_d = mem_data[CNT_W-1:0];
                end
            end
            RUNNING: begin
                if (wr_ctrl && !mem_data[0]) begin
                    state_d = IDLE;
                end else if (count_q != '0) begin
                    count_d = count_q - CNT_W'(1);
                end else begin
                    // Expiry sets the flag after the clear above, so a same-edge clear loses.
                    flag_d = 1'b1;
                    if (ctrl_q[2]) count_d = load_q;
                    else state_d = DONE;
                end
            end
            DONE: begin
                if (wr_ctrl) begin
                    state_d = mem_data[0] ? RUNNING : IDLE;
                    count_d = mem_data[0] ? load_q : count_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ctrl_q  <= '0;
            load_q  <= '0;
            count_q <= '0;
            flag_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            load_q  <= load_d;
            count_q <= count_d;
            flag_q  <= flag_d;
        end
    end
endmodule

// File: tb/tb_mmio_timer.sv
// tb_mmio_timer: directed self-checking bench for mmio_timer; undriven bus reads as all ones via tri1.
module tb_mmio_timer;
    localparam logic [31:0] BASE = 32'd248;
    localparam logic [63:0] FLOAT = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] mem_address = '0;
    logic        mem_cs = 1'b0;
    logic        mem_write_en = 1'b0;
    logic        mem_read = 1'b0;
    logic        timer_irq;
    logic [63:0] drv = '0;
    logic        drv_en = 1'b0;
    tri1  [63:0] mem_data;
    logic [63:0] v;
    int          n_checks = 0;
    int          n_errors = 0;

    assign mem_data = drv_en ? drv : 64'bz;

    mmio_timer dut (
        .clock(clock), .reset(reset), .mem_address(mem_address), .mem_data(mem_data),
        .mem_cs(mem_cs), .mem_write_en(mem_write_en), .mem_read(mem_read), .timer_irq(timer_irq)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [63:0] d);
        @(negedge clock);
        mem_address = a; mem_cs = 1'b1; mem_write_en = 1'b1; drv = d; drv_en = 1'b1;
        @(posedge clock);
        #1;
        mem_write_en = 1'b0; mem_cs = 1'b0; drv_en = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, input logic cs, output logic [63:0] d);
        @(negedge clock);
        mem_address = a; mem_cs = cs; mem_read = 1'b1;
        #1;
        d = mem_data;
        #1;
        mem_read = 1'b0; mem_cs = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clock);
        check("irq_in_reset", {63'b0, timer_irq}, 64'd0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus_read(BASE + i, 1'b1, v);
            check($sformatf("reset_reg%0d", i), v, 64'd0);
        end
        #2 check("bus_idle", mem_data, FLOAT);

        // One-shot countdown from 5.
        bus_write(BASE + 1, 64'd5);
        bus_write(BASE, 64'd1);
        for (int i = 5; i >= 0; i--) begin
            bus_read(BASE + 2, 1'b1, v);
            check($sformatf("oneshot_count%0d", i), v, 64'(i));
        end
        bus_read(BASE + 3, 1'b1, v);
        check("oneshot_status_done", v, 64'd1);
        bus_read(BASE + 2, 1'b1, v);
        check("oneshot_count_hold", v, 64'd0);
        bus_read(BASE + 2, 1'b0, v);
        check("read_cs0_float", v, FLOAT);
        bus_read(32'd254, 1'b1, v);
        check("read_addr254_float", v, FLOAT);

        // CTRL masks upper bits and the reserved bit; enable=0 drops DONE to IDLE.
        bus_write(BASE, 64'hFFFF_FFFF_FFFF_FFFE);
        bus_read(BASE, 1'b1, v);
        check("ctrl_mask", v, 64'hC);
        check("irq_on", {63'b0, timer_irq}, 64'd1);
        bus_write(BASE + 3, 64'd2);
        bus_read(BASE + 3, 1'b1, v);
        check("status_w0_noop", v, 64'd1);
        bus_write(BASE + 2, 64'd77);
        bus_read(BASE + 2, 1'b1, v);
        check("count_write_ignored", v, 64'd0);
        bus_write(BASE + 3, 64'd1);
        bus_read(BASE + 3, 1'b1, v);
        check("status_cleared", v, 64'd0);
        check("irq_off", {63'b0, timer_irq}, 64'd0);

        // Autoreload period LOAD+1 = 4, flag cleared by software each period.
        bus_write(BASE + 1, 64'd3);
        bus_write(BASE, 64'hD);
        for (int i = 0; i <= 12; i++) begin
            logic e;
            e = (i > 0) && (i % 4 == 0);
            @(negedge clock);
            mem_address = BASE + 3; mem_cs = 1'b1; mem_read = 1'b1;
            #1;
            check($sformatf("auto_irq_c%0d", i), {63'b0, timer_irq}, {63'b0, e});
            check($sformatf("auto_status_c%0d", i), mem_data, {62'b0, 1'b1, e});
            mem_read = 1'b0;
            if (e) begin
                mem_write_en = 1'b1; drv = 64'd1; drv_en = 1'b1;
            end
            @(posedge clock);
            #1;
            mem_write_en = 1'b0; drv_en = 1'b0; mem_cs = 1'b0;
        end

        // Expiry and software clear on the same edge: set wins.
        bus_write(BASE, 64'd0);
        bus_write(BASE + 3, 64'd1);
        bus_write(BASE + 1, 64'd2);
        bus_write(BASE, 64'hD);
        repeat (2) @(posedge clock);
        bus_write(BASE + 3, 64'd1);
        bus_read(BASE + 3, 1'b1, v);
        check("collide_status", v, 64'd3);
        check("collide_irq", {63'b0, timer_irq}, 64'd1);

        // Stop at count 7, hold, then restart from LOAD.
        bus_write(BASE, 64'd0);
        bus_write(BASE + 3, 64'd1);
        bus_write(BASE + 1, 64'd9);
        bus_write(BASE, 64'd1);
        repeat (2) @(posedge clock);
        bus_write(BASE, 64'd0);
        for (int i = 0; i < 10; i++) begin
            bus_read(BASE + 2, 1'b1, v);
            check($sformatf("stop_hold%0d", i), v, 64'd7);
        end
        bus_read(BASE + 3, 1'b1, v);
        check("stop_status", v, 64'd0);
        bus_write(BASE, 64'h9);
        bus_read(BASE + 2, 1'b1, v);
        check("restart_reload", v, 64'd9);

        // Reset mid-count at 2.
        repeat (7) @(posedge clock);
        bus_read(BASE + 2, 1'b1, v);
        check("pre_reset_count", v, 64'd2);
        reset = 1'b1;
        #1;
        check("reset_irq", {63'b0, timer_irq}, 64'd0);
        for (int i = 0; i < 4; i++) begin
            bus_read(BASE + i, 1'b1, v);
            check($sformatf("midreset_reg%0d", i), v, 64'd0);
        end
        @(negedge clock);
        reset = 1'b0;
        repeat (20) @(posedge clock);
        bus_read(BASE + 3, 1'b1, v);
        check("post_reset_status", v, 64'd0);
        bus_read(BASE + 2, 1'b1, v);
        check("post_reset_count", v, 64'd0);
        check("post_reset_irq", {63'b0, timer_irq}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/mmio_timer.md
MMIO_TIMER -- requirements
Module: mmio_timer

Interface
REQ-001 Parameter BASE_ADDRESS, default 32'd248, word address of register CTRL; LOAD is BASE+1, COUNT is BASE+2, STATUS is BASE+3.
REQ-002 Parameter CNT_W, default 32, width of the LOAD and COUNT registers.
REQ-003 clock  input  1  single system clock, rising-edge active.
REQ-004 reset  input  1  asynchronous, active-high; forces the reset state of Section Reset.
REQ-005 mem_address  input  32  word address from the datapath.
REQ-006 mem_data  inout  64  shared tri-state data bus.
REQ-007 mem_cs  input  1  data-memory select (mem_cs[0] of the control word).
REQ-008 mem_write_en  input  1  bus write strobe.
REQ-009 mem_read  input  1  bus read strobe.
REQ-010 timer_irq  output  1  interrupt request, level.
REQ-011 The block is a bus responder; it never initiates transfers.

Function
REQ-012 Hit is defined as: mem_cs=1 and mem_address is in BASE..BASE+3.
REQ-013 Write = hit & mem_write_en, sampled on the rising clock edge; Read = hit & mem_read & ~mem_write_en.
REQ-014 During Read, mem_data is driven combinationally with the addressed register, zero-extended to 64 bits; at all other times mem_data is 64'bz.
REQ-015 CTRL[3:0] = {irq_en, autoreload, reserved(0), enable}; writes take data[3:0]; bits 63:4 are ignored and read back as 0.
REQ-016 Read value of STATUS is {62'b0, running, flag}.
REQ-017 Writes to COUNT and to STATUS bits other than bit 0 are ignored.
REQ-018 A write to LOAD stores data[CNT_W-1:0]; if the state is IDLE, count is also loaded with the same value on that edge.
REQ-019 FSM states: IDLE, RUNNING, DONE.
REQ-020 IDLE -> RUNNING on a CTRL write with enable=1; count <= LOAD on that edge.
REQ-021 RUNNING with count>0: count decrements by 1 per clock.
REQ-022 RUNNING with count==0: flag <= 1.
REQ-023 On that same count==0 edge: if autoreload=1, count <= LOAD and the state stays RUNNING; otherwise the state goes to DONE and count holds at 0.
REQ-024 With autoreload=1, the period is LOAD+1 clocks per flag event; LOAD=0 sets the flag every clock.
REQ-025 RUNNING or DONE -> IDLE on a CTRL write with enable=0; count holds its current value.
REQ-026 DONE -> RUNNING on a CTRL write with enable=1; count <= LOAD.
REQ-027 A CTRL write with enable=1 while RUNNING updates the CTRL bits only: no reload and no restart.
REQ-028 running = (state==RUNNING).
REQ-029 A write to STATUS with data[0]=1 clears the flag; data[0]=0 has no effect.
REQ-030 If the flag-set and flag-clear conditions occur on the same edge, set wins and the flag reads 1.
REQ-031 timer_irq = flag & irq_en, registered-signal only, with no combinational path from the bus.
REQ-032 The counter never wraps: decrement occurs only when count>0.

Reset
REQ-033 On reset, asynchronously: CTRL=0, LOAD=0, count=0, flag=0, state=IDLE, timer_irq=0, mem_data=Z.
REQ-034 Reset asserted mid-count aborts the count immediately; no flag is set.
REQ-035 After reset deasserts, the block stays IDLE until a CTRL write.

Verification
REQ-036 Write LOAD=5, then CTRL=4'b0001 -> COUNT reads 5,4,3,2,1,0 on successive clocks; on the next edge flag=1 and state is DONE; COUNT stays 0.
REQ-037 Write LOAD=3 and CTRL=4'b1101 -> timer_irq rises every 4 clocks while the flag is cleared each period by STATUS writes of 1; running reads 1 throughout.
REQ-038 Flag expiry and a STATUS write of 1 on the same edge -> flag reads 1 and timer_irq stays 1.
REQ-039 Read BASE+2 with mem_cs=1 -> mem_data equals zero-extended count; same address with mem_cs=0, or address 254 -> mem_data is Z.
REQ-040 Write CTRL=0 while RUNNING at count=7 -> state IDLE, COUNT holds 7 over 10 clocks; a subsequent enable write reloads from LOAD.
REQ-041 Assert reset at count=2 while RUNNING -> all registers read 0, timer_irq=0, and no flag is set after release.
